sc1602_read_ctrl: RTL and testbench

Read-side controller for the SC1602 (HD44780-compatible) character LCD on its 4-bit bus. The write driver only ever drives the bus with RW=0; this block performs the opposite transaction. It runs RW=1 read cycles to fetch either the busy flag plus address counter (RS=0) or a data byte from DDRAM/CGRAM (RS=1), and can optionally poll the busy flag until it clears. It sits between the top level and the LCD pins and owns the pins only while `lcd_read_active` is high.

---
 rtl/sc1602_pkg.sv | 47 ++++
 rtl/sc1602_nibble_cycle.sv | 88 ++++++++
 rtl/sc1602_read_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_sc1602_read_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc1602_pkg.sv
// ---------------------------------------------------------------------------
// sc1602_pkg
// Shared definitions for the SC1602 (HD44780-compatible) LCD blocks.
//   - Read-controller state encoding and E-pulse phase encoding
//   - RS encodings (instruction/status register vs. data RAM)
//   - Default bus timing in sys_clk cycles for the 27 MHz clock domain.
//     The write driver uses the same constants.
//   - cntWidth(): counter width helper that never returns 0
// ---------------------------------------------------------------------------
package sc1602_pkg;

   localparam int CLK_HZ        = 27_000_000;
   localparam int CLK_PERIOD_NS = 1_000_000_000 / CLK_HZ;

   // tAS >= 40 ns, rounded up to whole 37 ns clock periods.
   localparam int DEF_SETUP_CYC   = (40 + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
   // 12 x 37 ns = 444 ns. This covers tDDR (160 ns) with generous margin.
   localparam int DEF_EN_HIGH_CYC = 12;
   localparam int DEF_EN_LOW_CYC  = 14;
   localparam int DEF_TURN_CYC    = 2;
   localparam int DEF_MAX_POLLS   = 4095;

   localparam logic RS_INSTR = 1'b0;
   localparam logic RS_DATA  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TURN,
      ST_SETUP,
      ST_EH1,
      ST_EL1,
      ST_EH2,
      ST_EL2,
      ST_DONE
   } rd_state_e;

   typedef enum logic [1:0] {
      NIB_IDLE,
      NIB_HIGH,
      NIB_LOW
   } nib_phase_e;

   function automatic int cntWidth(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sc1602_nibble_cycle.sv
// ---------------------------------------------------------------------------
// sc1602_nibble_cycle
// Runs one E pulse on the LCD bus: E high for EN_HIGH_CYC cycles, then
// E low for EN_LOW_CYC cycles.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : begin a pulse. Accepted when idle, or on the last
//                   low cycle so that pulses can run back to back.
//   en_o          : registered E pin
//   sample_o      : high on the last E-high cycle, so the parent captures
//                   the data nibble at the edge where E falls
//   done_o        : high on the last E-low cycle
// ---------------------------------------------------------------------------
module sc1602_nibble_cycle
   import sc1602_pkg::*;
#(
   parameter int EN_HIGH_CYC = DEF_EN_HIGH_CYC,
   parameter int EN_LOW_CYC  = DEF_EN_LOW_CYC
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic start_i,
   output logic en_o,
   output logic sample_o,
   output logic done_o
);

   localparam int CW = (cntWidth(EN_HIGH_CYC) > cntWidth(EN_LOW_CYC)) ?
                       cntWidth(EN_HIGH_CYC) : cntWidth(EN_LOW_CYC);
   localparam logic [CW-1:0] HIGH_LAST = CW'(EN_HIGH_CYC - 1);
   localparam logic [CW-1:0] LOW_LAST  = CW'(EN_LOW_CYC - 1);

   nib_phase_e    phase_q;
   logic [CW-1:0] cnt_q;
   logic          en_q;

   assign en_o     = en_q;
   assign sample_o = (phase_q == NIB_HIGH) && (cnt_q == HIGH_LAST);
   assign done_o   = (phase_q == NIB_LOW)  && (cnt_q == LOW_LAST);

   // Phase sequencer. A start on the last low cycle re-arms immediately,
   // so the second nibble follows the first without an idle gap.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         phase_q <= NIB_IDLE;
         cnt_q   <= '0;
         en_q    <= 1'b0;
      end else begin
         case (phase_q)
            NIB_IDLE: begin
               if (start_i) begin
                  phase_q <= NIB_HIGH;
                  en_q    <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            NIB_HIGH: begin
               if (cnt_q == HIGH_LAST) begin
                  phase_q <= NIB_LOW;
                  en_q    <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            NIB_LOW: begin
               if (cnt_q == LOW_LAST) begin
                  cnt_q <= '0;
                  if (start_i) begin
                     phase_q <= NIB_HIGH;
                     en_q    <= 1'b1;
                  end else begin
                     phase_q <= NIB_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               phase_q <= NIB_IDLE;
               en_q    <= 1'b0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/sc1602_read_ctrl.sv
// ---------------------------------------------------------------------------
// sc1602_read_ctrl
// Performs RW=1 read cycles on the SC1602 4-bit bus. It reads either the
// busy flag plus address counter (rs_sel=0) or a data byte (rs_sel=1).
// In poll mode it can repeat busy-flag reads until BF clears.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   req, rs_sel, poll  : start request. rs_sel and poll are latched at accept.
//   busy               : transaction in progress
//   rd_valid           : one-cycle pulse. rd_data and timeout are valid.
//   rd_data            : assembled byte, high nibble first
//   timeout            : poll limit reached
//   lcd_read_active    : this block owns RS/RW/E and the data pins
//   lcd_rs, lcd_rw, lcd_en : LCD control pins
//   lcd_d_in           : LCD D7..D4, already synchronized
// ---------------------------------------------------------------------------
module sc1602_read_ctrl
   import sc1602_pkg::*;
#(
   parameter int SETUP_CYC   = DEF_SETUP_CYC,
   parameter int EN_HIGH_CYC = DEF_EN_HIGH_CYC,
   parameter int EN_LOW_CYC  = DEF_EN_LOW_CYC,
   parameter int TURN_CYC    = DEF_TURN_CYC,
   parameter int MAX_POLLS   = DEF_MAX_POLLS
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       req,
   input  logic       rs_sel,
   input  logic       poll,
   output logic       busy,
   output logic       rd_valid,
   output logic [7:0] rd_data,
   output logic       timeout,
   output logic       lcd_read_active,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en,
   input  logic [3:0] lcd_d_in
);

   localparam int CW = (cntWidth(TURN_CYC) > cntWidth(SETUP_CYC)) ?
                       cntWidth(TURN_CYC) : cntWidth(SETUP_CYC);
   localparam int PW = cntWidth(MAX_POLLS);
   localparam logic [CW-1:0] TURN_LAST  = CW'(TURN_CYC - 1);
   localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
   localparam logic [PW-1:0] POLL_LAST  = PW'(MAX_POLLS - 1);

   rd_state_e     state_q;
   logic [CW-1:0] cnt_q;
   logic [PW-1:0] poll_cnt_q;
   logic          rs_q;
   logic          poll_q;
   logic          busy_q;
   logic          valid_q;
   logic          timeout_q;
   logic          active_q;
   logic          rw_q;
   logic [7:0]    data_q;

   logic          setup_last;
   logic          nib_start;
   logic          nib_sample;
   logic          nib_done;

   assign busy            = busy_q;
   assign rd_valid        = valid_q;
   assign rd_data         = data_q;
   assign timeout         = timeout_q;
   assign lcd_read_active = active_q;
   assign lcd_rs          = rs_q;
   assign lcd_rw          = rw_q;

   // The first E pulse starts from the end of SETUP. The second starts from
   // the last EL1 cycle, so that EL1 lasts exactly EN_LOW_CYC cycles.
   assign setup_last = (state_q == ST_SETUP) && (cnt_q == SETUP_LAST);
   assign nib_start  = setup_last || ((state_q == ST_EL1) && nib_done);

   sc1602_nibble_cycle #(
      .EN_HIGH_CYC (EN_HIGH_CYC),
      .EN_LOW_CYC  (EN_LOW_CYC)
   ) u_nibble (
      .clk_i    (sys_clk),
      .rst_ni   (sys_rst_n),
      .start_i  (nib_start),
      .en_o     (lcd_en),
      .sample_o (nib_sample),
      .done_o   (nib_done)
   );

   // Transaction sequencer. All pin-facing outputs are registered here, and
   // RS/RW only move in states where E is low. A poll iteration goes back to
   // SETUP with RW still high, because the bus is already turned around.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         poll_cnt_q <= '0;
         rs_q       <= 1'b0;
         poll_q     <= 1'b0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         timeout_q  <= 1'b0;
         active_q   <= 1'b0;
         rw_q       <= 1'b0;
         data_q     <= 8'h00;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req) begin
                  rs_q      <= rs_sel;
                  poll_q    <= poll && (rs_sel == RS_INSTR);
                  busy_q    <= 1'b1;
                  active_q  <= 1'b1;
                  timeout_q <= 1'b0;
                  cnt_q     <= '0;
                  state_q   <= ST_TURN;
               end
            end
            ST_TURN: begin
               if (cnt_q == TURN_LAST) begin
                  cnt_q   <= '0;
                  rw_q    <= 1'b1;
                  state_q <= ST_SETUP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_SETUP: begin
               if (setup_last) begin
                  cnt_q   <= '0;
                  state_q <= ST_EH1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_EH1: begin
               if (nib_sample) begin
                  data_q[7:4] <= lcd_d_in;
                  state_q     <= ST_EL1;
               end
            end
            ST_EL1: begin
               if (nib_done) begin
                  state_q <= ST_EH2;
               end
            end
            ST_EH2: begin
               if (nib_sample) begin
                  data_q[3:0] <= lcd_d_in;
                  state_q     <= ST_EL2;
               end
            end
            ST_EL2: begin
               if (nib_done) begin
                  if (!poll_q || !data_q[7]) begin
                     valid_q <= 1'b1;
                     state_q <= ST_DONE;
                  end else if (poll_cnt_q < POLL_LAST) begin
                     poll_cnt_q <= poll_cnt_q + 1'b1;
                     state_q    <= ST_SETUP;
                  end else begin
                     timeout_q <= 1'b1;
                     valid_q   <= 1'b1;
                     state_q   <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               valid_q    <= 1'b0;
               busy_q     <= 1'b0;
               rw_q       <= 1'b0;
               active_q   <= 1'b0;
               rs_q       <= 1'b0;
               poll_cnt_q <= '0;
               state_q    <= ST_IDLE;
            end
            default: begin
               state_q  <= ST_IDLE;
               busy_q   <= 1'b0;
               valid_q  <= 1'b0;
               active_q <= 1'b0;
               rw_q     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sc1602_read_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sc1602_read_ctrl
// Scoreboard bench for sc1602_read_ctrl. One instance uses the default
// timing, with a nibble-serving LCD model. A second instance uses
// MAX_POLLS=3 and has its data pins tied so that BF reads back as stuck at 1.
// ---------------------------------------------------------------------------
module tb_sc1602_read_ctrl;

   typedef struct {
      logic [7:0] data;
      logic       tmo;
      int         due;
   } exp_t;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic       req, rsSel, pollIn;
   logic       busy, rdValid, timeoutO, lcdActive, lcdRs, lcdRw, lcdEn;
   logic [7:0] rdData;
   logic [3:0] lcdDin;

   logic       reqT, rsSelT, pollT;
   logic       busyT, rdValidT, timeoutT, activeT, rsT, rwT, enT;
   logic [7:0] rdDataT;
   logic [3:0] lcdDinT;

   int         chkCnt = 0;
   int         errCnt = 0;
   int         cyc = 0;
   exp_t       expQ[$];
   exp_t       expTQ[$];
   exp_t       curExp, curExpT;

   logic [7:0] modelQ[$];
   logic [7:0] curByte;
   bit         nibLow;
   int         ePulses = 0;
   int         ePulsesT = 0;

   logic       expRs;
   logic       prevEn, prevRw, prevRs, prevAct;
   int         ehiCnt, actCnt;
   int         ctlBad = 0, ehiBad = 0, turnBad = 0, rwFallBad = 0, rsBad = 0;
   int         eWidths = 0;
   int         base;

   sc1602_read_ctrl dut (
      .sys_clk         (sys_clk),
      .sys_rst_n       (sys_rst_n),
      .req             (req),
      .rs_sel          (rsSel),
      .poll            (pollIn),
      .busy            (busy),
      .rd_valid        (rdValid),
      .rd_data         (rdData),
      .timeout         (timeoutO),
      .lcd_read_active (lcdActive),
      .lcd_rs          (lcdRs),
      .lcd_rw          (lcdRw),
      .lcd_en          (lcdEn),
      .lcd_d_in        (lcdDin)
   );

   sc1602_read_ctrl #(.MAX_POLLS(3)) dutT (
      .sys_clk         (sys_clk),
      .sys_rst_n       (sys_rst_n),
      .req             (reqT),
      .rs_sel          (rsSelT),
      .poll            (pollT),
      .busy            (busyT),
      .rd_valid        (rdValidT),
      .rd_data         (rdDataT),
      .timeout         (timeoutT),
      .lcd_read_active (activeT),
      .lcd_rs          (rsT),
      .lcd_rw          (rwT),
      .lcd_en          (enT),
      .lcd_d_in        (lcdDinT)
   );

   // 10 ns clock and a free-running cycle index used for latency checks
   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      chkCnt++;
      if (act !== exp) begin
         errCnt++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // LCD model: serve the high nibble on the first E pulse of a byte and the
   // low nibble on the second. When the model queue is empty it returns 00.
   always @(posedge lcdEn) begin
      ePulses++;
      if (!nibLow) begin
         curByte = (modelQ.size() > 0) ? modelQ.pop_front() : 8'h00;
         lcdDin  = curByte[7:4];
         nibLow  = 1'b1;
      end else begin
         lcdDin = curByte[3:0];
         nibLow = 1'b0;
      end
   end

   always @(posedge enT) ePulsesT++;

   // Scoreboard monitors: compare on every rd_valid pulse
   always @(negedge sys_clk) begin
      if (sys_rst_n && rdValid) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected rd_valid", 1, 0);
         end else begin
            curExp = expQ.pop_front();
            checkOutput("rd_data", rdData, curExp.data);
            checkOutput("timeout", timeoutO, curExp.tmo);
            checkOutput("latency", cyc, curExp.due);
         end
      end
   end

   always @(negedge sys_clk) begin
      if (sys_rst_n && rdValidT) begin
         if (expTQ.size() == 0) begin
            checkOutput("unexpected rd_valid T", 1, 0);
         end else begin
            curExpT = expTQ.pop_front();
            checkOutput("rd_data T", rdDataT, curExpT.data);
            checkOutput("timeout T", timeoutT, curExpT.tmo);
            checkOutput("latency T", cyc, curExpT.due);
         end
      end
   end

   // Bus protocol observer on the default instance
   always @(negedge sys_clk) begin
      if (!sys_rst_n) begin
         prevEn  = 1'b0;
         prevRw  = 1'b0;
         prevRs  = 1'b0;
         prevAct = 1'b0;
         ehiCnt  = 0;
         actCnt  = 0;
      end else begin
         if (((lcdRw !== prevRw) || (lcdRs !== prevRs)) && (lcdEn || prevEn))
            ctlBad++;
         if (lcdEn) begin
            ehiCnt++;
         end else if (prevEn) begin
            eWidths++;
            if (ehiCnt != 12) ehiBad++;
            ehiCnt = 0;
         end
         if (lcdRw && !prevRw && (actCnt < 2)) turnBad++;
         if ((lcdRw && !lcdActive) || (prevRw && !lcdRw && lcdActive))
            rwFallBad++;
         if (busy && (lcdRs !== expRs)) rsBad++;
         if (lcdActive) actCnt++;
         else actCnt = 0;
         prevEn  = lcdEn;
         prevRw  = lcdRw;
         prevRs  = lcdRs;
         prevAct = lcdActive;
      end
   end

   // Issue one request right after a negedge. Unless noExp is set, the
   // expected result is queued, due lat cycles after the request cycle.
   task automatic applyStimulus(input bit useT, input logic rs, input logic pl,
                                input logic [7:0] data, input logic tmo,
                                input int lat, input bit noExp);
      exp_t e;
      e.data = data;
      e.tmo  = tmo;
      e.due  = cyc + lat;
      if (useT) begin
         reqT = 1'b1; rsSelT = rs; pollT = pl;
         if (!noExp) expTQ.push_back(e);
      end else begin
         req = 1'b1; rsSel = rs; pollIn = pl; expRs = rs;
         if (!noExp) expQ.push_back(e);
      end
      @(negedge sys_clk);
      req  = 1'b0;
      reqT = 1'b0;
   endtask

   task automatic waitDone(input bit useT, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         if (useT ? (expTQ.size() == 0 && !busyT) : (expQ.size() == 0 && !busy))
            break;
         @(negedge sys_clk);
      end
      if (i == budget) begin
         checkOutput(useT ? "wait done T" : "wait done", 0, 1);
         if (useT) expTQ.delete();
         else expQ.delete();
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      sys_rst_n = 1'b0;
      req = 1'b0; rsSel = 1'b0; pollIn = 1'b0;
      reqT = 1'b0; rsSelT = 1'b0; pollT = 1'b0;
      lcdDin = 4'h0; lcdDinT = 4'hC;
      nibLow = 1'b0; expRs = 1'b0;
      repeat (3) @(negedge sys_clk);
      checkOutput("reset ctl", {busy, rdValid, timeoutO, lcdActive, lcdRs, lcdRw, lcdEn}, 7'd0);
      checkOutput("reset rd_data", rdData, 8'h00);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);

      $display("[TB] BF/AC read");
      base = ePulses;
      modelQ.push_back(8'h3A);
      applyStimulus(0, 1'b0, 1'b0, 8'h3A, 1'b0, 57, 0);
      waitDone(0, 200);
      checkOutput("bfac E pulses", ePulses - base, 2);

      $display("[TB] data read, poll ignored, stray req ignored");
      base = ePulses;
      modelQ.push_back(8'h46);
      applyStimulus(0, 1'b1, 1'b1, 8'h46, 1'b0, 57, 0);
      repeat (10) @(negedge sys_clk);
      req = 1'b1; rsSel = 1'b0; pollIn = 1'b1;
      @(negedge sys_clk);
      req = 1'b0;
      waitDone(0, 200);
      checkOutput("data E pulses", ePulses - base, 2);

      $display("[TB] data read with bit7 set, then back-to-back req");
      base = ePulses;
      modelQ.push_back(8'hC5);
      modelQ.push_back(8'h12);
      applyStimulus(0, 1'b1, 1'b1, 8'hC5, 1'b0, 57, 0);
      for (int i = 0; i < 200 && !rdValid; i++) @(negedge sys_clk);
      @(negedge sys_clk);
      checkOutput("busy after valid", busy, 1'b0);
      applyStimulus(0, 1'b0, 1'b0, 8'h12, 1'b0, 57, 0);
      waitDone(0, 200);
      checkOutput("b2b E pulses", ePulses - base, 4);

      $display("[TB] poll until BF clears");
      base = ePulses;
      modelQ.push_back(8'h8F);
      modelQ.push_back(8'h81);
      modelQ.push_back(8'hC0);
      modelQ.push_back(8'h05);
      applyStimulus(0, 1'b0, 1'b1, 8'h05, 1'b0, 219, 0);
      waitDone(0, 400);
      checkOutput("poll E pulses", ePulses - base, 8);

      $display("[TB] poll timeout with MAX_POLLS=3");
      base = ePulsesT;
      applyStimulus(1, 1'b0, 1'b1, 8'hCC, 1'b1, 165, 0);
      waitDone(1, 300);
      checkOutput("timeout E pulses", ePulsesT - base, 6);
      applyStimulus(1, 1'b1, 1'b0, 8'hCC, 1'b0, 57, 0);
      waitDone(1, 200);

      $display("[TB] protocol summary");
      checkOutput("RS/RW stable while E high", ctlBad, 0);
      checkOutput("E high width", ehiBad, 0);
      checkOutput("E pulses observed", eWidths, ePulses);
      checkOutput("RW after turnaround", turnBad, 0);
      checkOutput("RW falls with active", rwFallBad, 0);
      checkOutput("RS held during txn", rsBad, 0);

      $display("[TB] reset during EH2");
      base = ePulses;
      modelQ.push_back(8'h77);
      applyStimulus(0, 1'b1, 1'b0, 8'h77, 1'b0, 57, 1);
      for (int i = 0; i < 200 && !((ePulses == base + 2) && lcdEn); i++)
         @(negedge sys_clk);
      checkOutput("reached EH2", (ePulses == base + 2) && lcdEn, 1'b1);
      #2 sys_rst_n = 1'b0;
      #1;
      checkOutput("async reset pins", {lcdEn, lcdRw, lcdActive, busy}, 4'd0);
      repeat (3) @(negedge sys_clk);
      checkOutput("no rd_valid in reset", rdValid, 1'b0);
      sys_rst_n = 1'b1;
      modelQ.delete();
      nibLow = 1'b0;
      repeat (70) @(negedge sys_clk);
      base = ePulses;
      modelQ.push_back(8'h5C);
      applyStimulus(0, 1'b1, 1'b0, 8'h5C, 1'b0, 57, 0);
      waitDone(0, 200);
      checkOutput("post-reset E pulses", ePulses - base, 2);
      checkOutput("post-reset E width", ehiBad, 0);

      repeat (5) @(negedge sys_clk);
      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end

endmodule
